// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, working-state type, FSM encoding and the six logical functions.
// The optional double-hash path in the core is gated by SHA256_DOUBLE_HASH_EN.
package sha256_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ROUND,
      ST_FEED,
      ST_PASS2,
      ST_DONE
   } state_t;

   // Field order puts a in the most significant word, matching the H0-first digest layout.
   typedef struct packed {
      logic [31:0] a, b, c, d, e, f, g, h;
   } work_t;

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam work_t IV = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic work_t add_state(input work_t x, input work_t y);
      work_t r;
      r.a = x.a + y.a;
      r.b = x.b + y.b;
      r.c = x.c + y.c;
      r.d = x.d + y.d;
      r.e = x.e + y.e;
      r.f = x.f + y.f;
      r.g = x.g + y.g;
      r.h = x.h + y.h;
      return r;
   endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round: working state in, next working state out.
module sha256_round
   import sha256_pkg::*;
(
   input  work_t       cur,
   input  logic [31:0] k,
   input  logic [31:0] w,
   output work_t       nxt
);

   logic [31:0] t1, t2;

   assign t1 = cur.h + bsig1(cur.e) + ch(cur.e, cur.f, cur.g) + k + w;
   assign t2 = bsig0(cur.a) + maj(cur.a, cur.b, cur.c);

   assign nxt.a = t1 + t2;
   assign nxt.b = cur.a;
   assign nxt.c = cur.b;
   assign nxt.d = cur.c;
   assign nxt.e = cur.d + t1;
   assign nxt.f = cur.e;
   assign nxt.g = cur.f;
   assign nxt.h = cur.g;

endmodule

// File: rtl/sha256_iter_core.sv
// Iterative SHA-256 compression core, UNROLL rounds per clock, valid/ready in and out.
// Define SHA256_DOUBLE_HASH_EN to build the second pass over the digest (double SHA-256).
module sha256_iter_core
   import sha256_pkg::*;
#(
   parameter int UNROLL = 1
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [511:0] block,
   input  logic [255:0] midstate_in,
   input  logic         use_iv,
   input  logic         dbl_hash,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [255:0] digest,
   output logic         busy
);

   if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
      $error("sha256_iter_core: UNROLL must be 1, 2, 4 or 8");
   end

   localparam logic [5:0] STEP = 6'(UNROLL);
   localparam logic [5:0] LAST = 6'(64 - UNROLL);

   state_t      state;
   logic [5:0]  cnt;
   logic [31:0] win [0:15];
   logic [31:0] ext [0:15+UNROLL];
   work_t       work, chain, init, feed, rnd_out;
   logic        accept;

   assign accept = (state == ST_IDLE) && in_valid;
   assign init   = use_iv ? IV : work_t'(midstate_in);
   assign feed   = add_state(chain, work);

   // Window holds W[t..t+15]; the next UNROLL words are derived ahead of their use.
   always_comb begin
      for (int i = 0; i < 16; i++) ext[i] = win[i];
      for (int i = 16; i < 16 + UNROLL; i++)
         ext[i] = ssig1(ext[i-2]) + ext[i-7] + ssig0(ext[i-15]) + ext[i-16];
   end

   for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
      work_t      din, dout;
      logic [5:0] kidx;
      if (j == 0) begin : g_first
         assign din = work;
      end else begin : g_next
         assign din = g_rnd[j-1].dout;
      end
      assign kidx = cnt + 6'(j);
      sha256_round u_round (.cur(din), .k(K[kidx]), .w(win[j]), .nxt(dout));
   end
   assign rnd_out = g_rnd[UNROLL-1].dout;

`ifdef SHA256_DOUBLE_HASH_EN
   logic         dbl_q;
   logic [511:0] p2_blk;
   assign p2_blk = {chain, 1'b1, 191'b0, 64'd256};
`else
   logic unused_dbl;
   assign unused_dbl = dbl_hash;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         digest    <= '0;
`ifdef SHA256_DOUBLE_HASH_EN
         dbl_q     <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: if (in_valid) begin
               state    <= ST_ROUND;
               cnt      <= '0;
               in_ready <= 1'b0;
               busy     <= 1'b1;
`ifdef SHA256_DOUBLE_HASH_EN
               dbl_q    <= dbl_hash;
`endif
            end
            ST_ROUND: begin
               cnt <= cnt + STEP;
               if (cnt == LAST) state <= ST_FEED;
            end
            ST_FEED: begin
`ifdef SHA256_DOUBLE_HASH_EN
               if (dbl_q) state <= ST_PASS2;
               else
`endif
               begin
                  digest    <= feed;
                  out_valid <= 1'b1;
                  state     <= ST_DONE;
               end
            end
`ifdef SHA256_DOUBLE_HASH_EN
            ST_PASS2: begin
               cnt   <= '0;
               dbl_q <= 1'b0;
               state <= ST_ROUND;
            end
`endif
            ST_DONE: if (out_ready) begin
               state     <= ST_IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Datapath registers carry no reset; the FSM decides when their contents matter.
   always_ff @(posedge clock) begin
      if (accept) begin
         for (int i = 0; i < 16; i++) win[i] <= block[511 - 32*i -: 32];
         chain <= init;
         work  <= init;
      end else if (state == ST_ROUND) begin
         for (int i = 0; i < 16; i++) win[i] <= ext[i + UNROLL];
         work <= rnd_out;
`ifdef SHA256_DOUBLE_HASH_EN
      end else if (state == ST_FEED && dbl_q) begin
         chain <= feed;
      end else if (state == ST_PASS2) begin
         for (int i = 0; i < 16; i++) win[i] <= p2_blk[511 - 32*i -: 32];
         chain <= IV;
         work  <= IV;
`endif
      end
   end

endmodule

// File: tb/tb_sha256_iter_core.sv
// Directed bench for sha256_iter_core with UNROLL = 1, 4 and 2 instances and known digests.
module tb_sha256_iter_core;

   localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] B_HELLO = {32'h68656c6c, 32'h6f20776f, 32'h726c6480, 384'h0, 32'h00000058};
   localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
   localparam logic [511:0] B_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] B_TWO2  = {480'h0, 32'h000001c0};

   localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] D_HELLO = 256'hb94d27b9934d3e08a52e52d7da7dabfac484efe37a5380ee9088f7ace2efcde9;
   localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] D_TWO1  = 256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
   localparam logic [255:0] D_TWO2  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
   localparam logic [255:0] D_DBL   = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;

   logic         clock = 1'b0;
   logic         reset_n;
   logic         in_valid [3];
   logic         in_ready [3];
   logic [511:0] blk [3];
   logic [255:0] mid [3];
   logic         use_iv [3];
   logic         dbl_hash [3];
   logic         out_valid [3];
   logic         out_ready [3];
   logic [255:0] digest [3];
   logic         busy [3];

   int checks = 0;
   int failures = 0;
   int lat;

   always #5 clock = ~clock;

   sha256_iter_core #(.UNROLL(1)) u0 (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .block(blk[0]), .midstate_in(mid[0]), .use_iv(use_iv[0]), .dbl_hash(dbl_hash[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .digest(digest[0]), .busy(busy[0]));

   sha256_iter_core #(.UNROLL(4)) u1 (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .block(blk[1]), .midstate_in(mid[1]), .use_iv(use_iv[1]), .dbl_hash(dbl_hash[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .digest(digest[1]), .busy(busy[1]));

   sha256_iter_core #(.UNROLL(2)) u2 (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .block(blk[2]), .midstate_in(mid[2]), .use_iv(use_iv[2]), .dbl_hash(dbl_hash[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .digest(digest[2]), .busy(busy[2]));

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic start(input int d, input logic [511:0] b, input logic [255:0] m,
                        input logic iv, input logic dbl);
      @(negedge clock);
      blk[d] = b; mid[d] = m; use_iv[d] = iv; dbl_hash[d] = dbl; in_valid[d] = 1'b1;
      @(posedge clock);
      #1 in_valid[d] = 1'b0;
      blk[d] = '0; mid[d] = '0; use_iv[d] = 1'b0; dbl_hash[d] = 1'b0;
   endtask

   task automatic wait_out(input int d);
      lat = 0;
      while (!out_valid[d] && lat < 300) begin
         @(posedge clock);
         #1 lat++;
      end
   endtask

   task automatic run_txn(input int d, input string tag, input logic [511:0] b, input logic [255:0] m,
                          input logic iv, input logic dbl, input int exp_lat, input logic [255:0] exp_dig);
      @(negedge clock);
      check({tag, "_in_ready_idle"}, 256'(in_ready[d]), 256'(1));
      start(d, b, m, iv, dbl);
      check({tag, "_busy"}, 256'(busy[d]), 256'(1));
      check({tag, "_in_ready_busy"}, 256'(in_ready[d]), 256'(0));
      wait_out(d);
      check({tag, "_latency"}, 256'(lat), 256'(exp_lat));
      check({tag, "_digest"}, digest[d], exp_dig);
      @(posedge clock);
      #1;
      check({tag, "_handoff_valid"}, 256'(out_valid[d]), 256'(0));
      check({tag, "_handoff_busy"}, 256'(busy[d]), 256'(0));
      check({tag, "_handoff_ready"}, 256'(in_ready[d]), 256'(1));
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         in_valid[i] = 1'b0; blk[i] = '0; mid[i] = '0;
         use_iv[i] = 1'b0; dbl_hash[i] = 1'b0; out_ready[i] = 1'b1;
      end
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_out_valid", 256'(out_valid[0]), 256'(0));
      check("rst_busy", 256'(busy[0]), 256'(0));
      check("rst_digest", digest[0], 256'(0));
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      check("rel_in_ready", 256'(in_ready[0]), 256'(1));
      check("rel_out_valid_u1", 256'(out_valid[1]), 256'(0));

      run_txn(0, "abc_u1", B_ABC, '0, 1'b1, 1'b0, 65, D_ABC);
      run_txn(1, "hello_u4", B_HELLO, '0, 1'b1, 1'b0, 17, D_HELLO);
      run_txn(1, "two_blk1", B_TWO1, '0, 1'b1, 1'b0, 17, D_TWO1);
      run_txn(1, "two_blk2", B_TWO2, D_TWO1, 1'b0, 1'b0, 17, D_TWO2);
      // midstate_in must be ignored when use_iv is set
      run_txn(2, "abc_iv_over_mid", B_ABC, D_TWO1, 1'b1, 1'b0, 33, D_ABC);
`ifdef SHA256_DOUBLE_HASH_EN
      run_txn(2, "dbl_u2", B_ABC, '0, 1'b1, 1'b1, 67, D_DBL);
`else
      run_txn(2, "dbl_ignored_u2", B_ABC, '0, 1'b1, 1'b1, 33, D_ABC);
`endif

      // Backpressure: hold the digest and ignore new requests.
      @(negedge clock);
      out_ready[1] = 1'b0;
      start(1, B_ABC, '0, 1'b1, 1'b0);
      wait_out(1);
      check("bp_latency", 256'(lat), 256'(17));
      check("bp_digest", digest[1], D_ABC);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         in_valid[1] = 1'b1;
         blk[1] = B_EMPTY;
         use_iv[1] = 1'b1;
         @(posedge clock);
         #1;
         check("bp_hold_valid", 256'(out_valid[1]), 256'(1));
         check("bp_hold_digest", digest[1], D_ABC);
         check("bp_hold_in_ready", 256'(in_ready[1]), 256'(0));
      end
      @(negedge clock);
      in_valid[1] = 1'b0;
      out_ready[1] = 1'b1;
      @(posedge clock);
      #1;
      check("bp_handoff_valid", 256'(out_valid[1]), 256'(0));
      check("bp_handoff_busy", 256'(busy[1]), 256'(0));
      check("bp_handoff_ready", 256'(in_ready[1]), 256'(1));
      run_txn(1, "empty_u4", B_EMPTY, '0, 1'b1, 1'b0, 17, D_EMPTY);

      // Reset in the middle of ROUND discards the transaction.
      start(0, B_HELLO, '0, 1'b1, 1'b0);
      repeat (30) @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      check("midrst_out_valid", 256'(out_valid[0]), 256'(0));
      check("midrst_busy", 256'(busy[0]), 256'(0));
      check("midrst_digest", digest[0], 256'(0));
      check("midrst_in_ready", 256'(in_ready[0]), 256'(1));
      @(negedge clock);
      reset_n = 1'b1;
      repeat (5) @(posedge clock);
      #1;
      check("midrst_no_output", 256'(out_valid[0]), 256'(0));
      run_txn(0, "abc_after_rst", B_ABC, '0, 1'b1, 1'b0, 65, D_ABC);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
